// File: rtl/mqnic_l2_ingress_mcf_pkg.sv
// Shared constants and FSM state encoding for the L2 ingress MCF block.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mqnic_l2_ingress_mcf_pkg;

  localparam logic [15:0] MCF_ETHERTYPE = 16'h8808;
  localparam logic [47:0] MCF_DST_MCAST = 48'h0180C2000001;
  localparam logic [15:0] OPCODE_LFC    = 16'h0001;
  localparam logic [15:0] OPCODE_PFC    = 16'h0101;

  // dst(6) + src(6) + ethertype(2) + opcode(2)
  localparam int MCF_HDR_BYTES = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FWD      = 2'd1,
    ST_MCF_FWD  = 2'd2,
    ST_MCF_DROP = 2'd3
  } state_t;

endpackage

// File: rtl/mqnic_l2_ingress_reg.sv
// Single-stage AXI-stream register carrying tid/tdest/tuser.
// Latency: 1 cycle from accepted input beat to output valid.
// Backpressure: s_tready = m_tready | ~m_tvalid (full throughput, no skid).
module mqnic_l2_ingress_reg #(
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int USER_WIDTH = 1,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic [KEEP_WIDTH-1:0] s_tkeep,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  input  logic [USER_WIDTH-1:0] s_tuser,
  input  logic [ID_WIDTH-1:0]   s_tid,
  input  logic [DEST_WIDTH-1:0] s_tdest,

  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic [KEEP_WIDTH-1:0] m_tkeep,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic [USER_WIDTH-1:0] m_tuser,
  output logic [ID_WIDTH-1:0]   m_tid,
  output logic [DEST_WIDTH-1:0] m_tdest
);

  logic [DATA_WIDTH-1:0] tdata_q,  tdata_d;
  logic [KEEP_WIDTH-1:0] tkeep_q,  tkeep_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q,  tlast_d;
  logic [USER_WIDTH-1:0] tuser_q,  tuser_d;
  logic [ID_WIDTH-1:0]   tid_q,    tid_d;
  logic [DEST_WIDTH-1:0] tdest_q,  tdest_d;

  assign s_tready = m_tready | ~tvalid_q;

  // Load on an accepted input beat, otherwise empty once the sink takes the beat.
  always_comb begin
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tuser_d  = tuser_q;
    tid_d    = tid_q;
    tdest_d  = tdest_q;
    if (s_tvalid && s_tready) begin
      tdata_d  = s_tdata;
      tkeep_d  = s_tkeep;
      tvalid_d = 1'b1;
      tlast_d  = s_tlast;
      tuser_d  = s_tuser;
      tid_d    = s_tid;
      tdest_d  = s_tdest;
    end else if (m_tready) begin
      tvalid_d = 1'b0;
    end
  end

  // Output register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tuser_q  <= '0;
      tid_q    <= '0;
      tdest_q  <= '0;
    end else begin
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tuser_q  <= tuser_d;
      tid_q    <= tid_d;
      tdest_q  <= tdest_d;
    end
  end

  assign m_tdata  = tdata_q;
  assign m_tkeep  = tkeep_q;
  assign m_tvalid = tvalid_q;
  assign m_tlast  = tlast_q;
  assign m_tuser  = tuser_q;
  assign m_tid    = tid_q;
  assign m_tdest  = tdest_q;

endmodule

// File: rtl/mqnic_l2_ingress_mcf.sv
// RX L2 ingress: classifies frames, extracts MAC control frames into mcf_*, forwards data frames.
// Latency: data 1 cycle; mcf_valid pulses the cycle after the MCF's accepted tlast.
// Backpressure: forwarded frames follow m_axis_tready; dropped MCFs are always accepted; mcf_* has none.
module mqnic_l2_ingress_mcf
  import mqnic_l2_ingress_mcf_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = 256,
  parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH/8,
  parameter int AXIS_USER_WIDTH = 1,
  parameter int ID_WIDTH        = 8,
  parameter int DEST_WIDTH      = 8,
  parameter int MCF_PARAMS_SIZE = 18
) (
  input  logic                         clk,
  input  logic                         rst,

  input  logic [AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic                         s_axis_tlast,
  input  logic [AXIS_USER_WIDTH-1:0]   s_axis_tuser,
  input  logic [ID_WIDTH-1:0]          s_axis_tid,
  input  logic [DEST_WIDTH-1:0]        s_axis_tdest,

  output logic [AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]   m_axis_tkeep,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic [AXIS_USER_WIDTH-1:0]   m_axis_tuser,
  output logic [ID_WIDTH-1:0]          m_axis_tid,
  output logic [DEST_WIDTH-1:0]        m_axis_tdest,

  output logic                         mcf_valid,
  output logic [47:0]                  mcf_eth_dst,
  output logic [47:0]                  mcf_eth_src,
  output logic [15:0]                  mcf_eth_type,
  output logic [15:0]                  mcf_opcode,
  output logic [MCF_PARAMS_SIZE*8-1:0] mcf_params,
  output logic [ID_WIDTH-1:0]          mcf_id,
  output logic [DEST_WIDTH-1:0]        mcf_dest,
  output logic [AXIS_USER_WIDTH-1:0]   mcf_user,

  input  logic                         cfg_mcf_rx_enable,
  input  logic [15:0]                  cfg_mcf_rx_eth_type,
  input  logic [47:0]                  cfg_mcf_rx_eth_dst_ucast,
  input  logic                         cfg_mcf_rx_check_eth_dst_ucast,
  input  logic                         cfg_mcf_rx_forward,

  output logic                         stat_rx_mcf
);

  localparam int HDR_LEN = MCF_HDR_BYTES + MCF_PARAMS_SIZE;
  localparam int LANE_W  = $clog2(AXIS_KEEP_WIDTH);

  state_t state_q, state_d;

  logic [15:0]                  ptr_q, ptr_d;
  logic [HDR_LEN*8-1:0]         hdr_q, hdr_d;

  logic                         mcf_valid_q, mcf_valid_d;
  logic [47:0]                  dst_q, dst_d;
  logic [47:0]                  src_q, src_d;
  logic [15:0]                  type_q, type_d;
  logic [15:0]                  opcode_q, opcode_d;
  logic [MCF_PARAMS_SIZE*8-1:0] params_q, params_d;
  logic [ID_WIDTH-1:0]          id_q, id_d;
  logic [DEST_WIDTH-1:0]        dest_q, dest_d;
  logic [AXIS_USER_WIDTH-1:0]   user_q, user_d;

  logic [47:0]                  beat_dst;
  logic [15:0]                  beat_type;
  logic                         is_mcf;
  logic                         frame_mcf;
  logic                         drop_beat;
  logic                         reg_s_tready;
  logic                         s_fire;
  logic [15:0]                  byte_cnt;
  logic [16:0]                  len_sum;
  logic [16:0]                  ptr_sum;
  logic [15:0]                  lane;
  logic                         mcf_done;

  // Beat-0 classifier: only meaningful while IDLE, where the current beat is the frame start.
  always_comb begin
    beat_dst = '0;
    for (int k = 0; k < 6; k++) begin
      beat_dst[47-8*k -: 8] = s_axis_tdata[8*k +: 8];
    end
    beat_type = {s_axis_tdata[8*12 +: 8], s_axis_tdata[8*13 +: 8]};
    is_mcf = cfg_mcf_rx_enable &&
             (beat_type == cfg_mcf_rx_eth_type) &&
             ((beat_dst == MCF_DST_MCAST) ||
              (cfg_mcf_rx_check_eth_dst_ucast && (beat_dst == cfg_mcf_rx_eth_dst_ucast)));
  end

  // FSM next state plus per-beat steering; cfg only influences the decision taken in IDLE.
  always_comb begin
    state_d   = state_q;
    frame_mcf = 1'b0;
    drop_beat = 1'b0;
    case (state_q)
      ST_IDLE: begin
        frame_mcf = is_mcf;
        drop_beat = is_mcf && !cfg_mcf_rx_forward;
        if (s_fire && !s_axis_tlast) begin
          if (!is_mcf)                 state_d = ST_FWD;
          else if (cfg_mcf_rx_forward) state_d = ST_MCF_FWD;
          else                         state_d = ST_MCF_DROP;
        end
      end
      ST_FWD: begin
        if (s_fire && s_axis_tlast) state_d = ST_IDLE;
      end
      ST_MCF_FWD: begin
        frame_mcf = 1'b1;
        if (s_fire && s_axis_tlast) state_d = ST_IDLE;
      end
      ST_MCF_DROP: begin
        frame_mcf = 1'b1;
        drop_beat = 1'b1;
        if (s_fire && s_axis_tlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Dropped beats bypass the register so they never stall on, or appear at, m_axis.
  assign s_axis_tready = !rst && (drop_beat || reg_s_tready);
  assign s_fire        = s_axis_tvalid && s_axis_tready;

  // Byte pointer, last-beat length and header capture into the fixed-size buffer.
  always_comb begin
    byte_cnt = '0;
    for (int i = 0; i < AXIS_KEEP_WIDTH; i++) begin
      byte_cnt = byte_cnt + 16'(s_axis_tkeep[i]);
    end
    len_sum = {1'b0, ptr_q} + {1'b0, byte_cnt};
    ptr_sum = {1'b0, ptr_q} + 17'(AXIS_KEEP_WIDTH);

    ptr_d = ptr_q;
    if (s_fire) begin
      if (s_axis_tlast)    ptr_d = '0;
      else if (ptr_sum[16]) ptr_d = 16'hFFFF;
      else                 ptr_d = ptr_sum[15:0];
    end

    hdr_d = hdr_q;
    lane  = '0;
    if (s_fire) begin
      for (int j = 0; j < HDR_LEN; j++) begin
        if (16'(j) >= ptr_q) begin
          lane = 16'(j) - ptr_q;
          if (lane < 16'(AXIS_KEEP_WIDTH)) begin
            hdr_d[8*j +: 8] = s_axis_tdata[{lane[LANE_W-1:0], 3'b000} +: 8];
          end
        end
      end
    end

    mcf_done = s_fire && s_axis_tlast && frame_mcf &&
               (len_sum >= 17'(HDR_LEN)) && !s_axis_tuser[0];
  end

  // Latch the decoded MCF record together with the pulse; fields hold between MCFs.
  always_comb begin
    mcf_valid_d = mcf_done;
    dst_d       = dst_q;
    src_d       = src_q;
    type_d      = type_q;
    opcode_d    = opcode_q;
    params_d    = params_q;
    id_d        = id_q;
    dest_d      = dest_q;
    user_d      = user_q;
    if (mcf_done) begin
      for (int k = 0; k < 6; k++) begin
        dst_d[47-8*k -: 8] = hdr_d[8*k +: 8];
        src_d[47-8*k -: 8] = hdr_d[8*(k+6) +: 8];
      end
      type_d   = {hdr_d[8*12 +: 8], hdr_d[8*13 +: 8]};
      opcode_d = {hdr_d[8*14 +: 8], hdr_d[8*15 +: 8]};
      params_d = hdr_d[HDR_LEN*8-1 -: MCF_PARAMS_SIZE*8];
      id_d     = s_axis_tid;
      dest_d   = s_axis_tdest;
      user_d   = s_axis_tuser;
    end
  end

  // State, capture and MCF record registers; reset abandons any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      hdr_q       <= '0;
      mcf_valid_q <= 1'b0;
      dst_q       <= '0;
      src_q       <= '0;
      type_q      <= '0;
      opcode_q    <= '0;
      params_q    <= '0;
      id_q        <= '0;
      dest_q      <= '0;
      user_q      <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hdr_q       <= hdr_d;
      mcf_valid_q <= mcf_valid_d;
      dst_q       <= dst_d;
      src_q       <= src_d;
      type_q      <= type_d;
      opcode_q    <= opcode_d;
      params_q    <= params_d;
      id_q        <= id_d;
      dest_q      <= dest_d;
      user_q      <= user_d;
    end
  end

  assign mcf_valid    = mcf_valid_q;
  assign stat_rx_mcf  = mcf_valid_q;
  assign mcf_eth_dst  = dst_q;
  assign mcf_eth_src  = src_q;
  assign mcf_eth_type = type_q;
  assign mcf_opcode   = opcode_q;
  assign mcf_params   = params_q;
  assign mcf_id       = id_q;
  assign mcf_dest     = dest_q;
  assign mcf_user     = user_q;

  mqnic_l2_ingress_reg #(
    .DATA_WIDTH (AXIS_DATA_WIDTH),
    .KEEP_WIDTH (AXIS_KEEP_WIDTH),
    .USER_WIDTH (AXIS_USER_WIDTH),
    .ID_WIDTH   (ID_WIDTH),
    .DEST_WIDTH (DEST_WIDTH)
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .s_tdata  (s_axis_tdata),
    .s_tkeep  (s_axis_tkeep),
    .s_tvalid (s_axis_tvalid && !drop_beat && !rst),
    .s_tready (reg_s_tready),
    .s_tlast  (s_axis_tlast),
    .s_tuser  (s_axis_tuser),
    .s_tid    (s_axis_tid),
    .s_tdest  (s_axis_tdest),
    .m_tdata  (m_axis_tdata),
    .m_tkeep  (m_axis_tkeep),
    .m_tvalid (m_axis_tvalid),
    .m_tready (m_axis_tready),
    .m_tlast  (m_axis_tlast),
    .m_tuser  (m_axis_tuser),
    .m_tid    (m_axis_tid),
    .m_tdest  (m_axis_tdest)
  );

endmodule

// File: tb/tb_mqnic_l2_ingress_mcf.sv
// Directed bench for mqnic_l2_ingress_mcf at 256-bit width.
// Latency: checks 1-cycle data path and post-tlast mcf pulse.
// Backpressure: drives m_axis_tready steady or alternating per vector.
module tb_mqnic_l2_ingress_mcf;

  localparam logic [47:0] MC   = 48'h0180C2000001;
  localparam logic [47:0] UC   = 48'h020000000001;
  localparam logic [47:0] SRC  = 48'h021122334455;

  typedef struct {
    bit          en;
    logic [47:0] dst;
    logic [15:0] etype;
    logic [15:0] op;
    int          len;
    bit          bad;
    bit          fwd;
    bit          chk;
    logic [7:0]  tid;
    bit          tog;
    bit          exp_pulse;
    bit          exp_fwd;
    logic [15:0] exp_op;
  } vec_t;

  typedef struct {
    logic [255:0] data;
    logic [31:0]  keep;
    logic         last;
    logic         user;
    logic [7:0]   tid;
    logic [7:0]   dest;
    bit           drop;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [255:0] s_axis_tdata = '0;
  logic [31:0]  s_axis_tkeep = '0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic         s_axis_tlast = 1'b0;
  logic [0:0]   s_axis_tuser = '0;
  logic [7:0]   s_axis_tid = '0;
  logic [7:0]   s_axis_tdest = '0;
  logic [255:0] m_axis_tdata;
  logic [31:0]  m_axis_tkeep;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b1;
  logic         m_axis_tlast;
  logic [0:0]   m_axis_tuser;
  logic [7:0]   m_axis_tid;
  logic [7:0]   m_axis_tdest;
  logic         mcf_valid;
  logic [47:0]  mcf_eth_dst;
  logic [47:0]  mcf_eth_src;
  logic [15:0]  mcf_eth_type;
  logic [15:0]  mcf_opcode;
  logic [143:0] mcf_params;
  logic [7:0]   mcf_id;
  logic [7:0]   mcf_dest;
  logic [0:0]   mcf_user;
  logic         cfg_mcf_rx_enable = 1'b1;
  logic [15:0]  cfg_mcf_rx_eth_type = 16'h8808;
  logic [47:0]  cfg_mcf_rx_eth_dst_ucast = UC;
  logic         cfg_mcf_rx_check_eth_dst_ucast = 1'b0;
  logic         cfg_mcf_rx_forward = 1'b0;
  logic         stat_rx_mcf;

  int    n_vec = 0;
  int    n_err = 0;
  int    pulse_cnt, stat_cnt, extra_beats, ready_low;
  bit    tog = 1'b0;
  beat_t in_q[$];
  beat_t exp_q[$];
  vec_t  vecs[12];

  always #5 clk = ~clk;

  mqnic_l2_ingress_mcf dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .s_axis_tid(s_axis_tid), .s_axis_tdest(s_axis_tdest),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .m_axis_tid(m_axis_tid), .m_axis_tdest(m_axis_tdest),
    .mcf_valid(mcf_valid), .mcf_eth_dst(mcf_eth_dst), .mcf_eth_src(mcf_eth_src),
    .mcf_eth_type(mcf_eth_type), .mcf_opcode(mcf_opcode), .mcf_params(mcf_params),
    .mcf_id(mcf_id), .mcf_dest(mcf_dest), .mcf_user(mcf_user),
    .cfg_mcf_rx_enable(cfg_mcf_rx_enable), .cfg_mcf_rx_eth_type(cfg_mcf_rx_eth_type),
    .cfg_mcf_rx_eth_dst_ucast(cfg_mcf_rx_eth_dst_ucast),
    .cfg_mcf_rx_check_eth_dst_ucast(cfg_mcf_rx_check_eth_dst_ucast),
    .cfg_mcf_rx_forward(cfg_mcf_rx_forward),
    .stat_rx_mcf(stat_rx_mcf)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] frame_byte(input vec_t v, input int n);
    logic [7:0] b;
    if (n < 6)        b = v.dst[47-8*n -: 8];
    else if (n < 12)  b = SRC[47-8*(n-6) -: 8];
    else if (n == 12) b = v.etype[15:8];
    else if (n == 13) b = v.etype[7:0];
    else if (n == 14) b = v.op[15:8];
    else if (n == 15) b = v.op[7:0];
    else if (n < 18)  b = 8'hFF;
    else              b = 8'(n) ^ 8'h5A;
    return b;
  endfunction

  task automatic add_frame(input vec_t v);
    int nb;
    beat_t b;
    nb = (v.len + 31) / 32;
    for (int k = 0; k < nb; k++) begin
      b.data = '0;
      b.keep = '0;
      for (int i = 0; i < 32; i++) begin
        if (32*k + i < v.len) begin
          b.data[8*i +: 8] = frame_byte(v, 32*k + i);
          b.keep[i] = 1'b1;
        end
      end
      b.last = (k == nb - 1);
      b.user = b.last && v.bad;
      b.tid  = v.tid;
      b.dest = ~v.tid;
      b.drop = !v.exp_fwd;
      in_q.push_back(b);
      if (v.exp_fwd) exp_q.push_back(b);
    end
  endtask

  task automatic set_cfg(input vec_t v);
    cfg_mcf_rx_enable              = v.en;
    cfg_mcf_rx_forward             = v.fwd;
    cfg_mcf_rx_check_eth_dst_ucast = v.chk;
    tog                            = v.tog;
  endtask

  task automatic clear_counts();
    pulse_cnt = 0; stat_cnt = 0; extra_beats = 0; ready_low = 0;
  endtask

  // One clock: inputs change at negedge, transfers are predicted #1 later for the coming posedge.
  task automatic step();
    beat_t e;
    @(negedge clk);
    if (mcf_valid)   pulse_cnt++;
    if (stat_rx_mcf) stat_cnt++;
    m_axis_tready = tog ? ~m_axis_tready : 1'b1;
    if (in_q.size() != 0) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = in_q[0].data;
      s_axis_tkeep  = in_q[0].keep;
      s_axis_tlast  = in_q[0].last;
      s_axis_tuser  = in_q[0].user;
      s_axis_tid    = in_q[0].tid;
      s_axis_tdest  = in_q[0].dest;
    end else begin
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tkeep  = '0;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = '0;
    end
    #1;
    if (s_axis_tvalid) begin
      if (in_q[0].drop && !s_axis_tready) ready_low++;
      if (s_axis_tready) in_q.delete(0);
    end
    if (m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) extra_beats++;
      else begin
        e = exp_q.pop_front();
        check("out_data", m_axis_tdata, e.data);
        check("out_meta", 256'({m_axis_tkeep, m_axis_tlast, m_axis_tuser, m_axis_tid, m_axis_tdest}),
              256'({e.keep, e.last, e.user, e.tid, e.dest}));
      end
    end
  endtask

  task automatic drain(input string name);
    int idle;
    idle = 0;
    for (int c = 0; c < 400 && idle < 4; c++) begin
      step();
      if (in_q.size() == 0 && !m_axis_tvalid) idle++;
      else idle = 0;
    end
    check({name, " timeout"},     256'(idle >= 4), 256'(1));
    check({name, " leftover"},    256'(exp_q.size()), 256'(0));
    check({name, " extra_beats"}, 256'(extra_beats), 256'(0));
    check({name, " drop_rdy_low"},256'(ready_low), 256'(0));
    check({name, " stat_cnt"},    256'(stat_cnt), 256'(pulse_cnt));
  endtask

  task automatic check_fields(input string name, input logic [15:0] op, input logic [47:0] dst,
                              input logic [7:0] tid);
    check({name, " opcode"},  256'(mcf_opcode), 256'(op));
    check({name, " dst"},     256'(mcf_eth_dst), 256'(dst));
    check({name, " src"},     256'(mcf_eth_src), 256'(SRC));
    check({name, " type"},    256'(mcf_eth_type), 256'(16'h8808));
    check({name, " quanta"},  256'(mcf_params[15:0]), 256'(16'hFFFF));
    check({name, " par18"},   256'(mcf_params[23:16]), 256'(8'h48));
    check({name, " par33"},   256'(mcf_params[143:136]), 256'(8'h7B));
    check({name, " id_dest"}, 256'({mcf_id, mcf_dest, mcf_user}), 256'({tid, ~tid, 1'b0}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t d0, lf, d1;
    //          en dst           type      op        len bad fwd chk tid    tog pul fwd exp_op
    vecs[0]  = '{1, 48'h020000000009, 16'h0800, 16'h4500, 64, 0, 0, 0, 8'h10, 0, 0, 1, 16'h0000};
    vecs[1]  = '{1, MC,           16'h8808, 16'h0001, 64, 0, 0, 0, 8'h11, 0, 1, 0, 16'h0001};
    vecs[2]  = '{1, UC,           16'h8808, 16'h0101, 64, 0, 1, 1, 8'h12, 0, 1, 1, 16'h0101};
    vecs[3]  = '{1, UC,           16'h8808, 16'h0101, 64, 0, 1, 0, 8'h13, 0, 0, 1, 16'h0000};
    vecs[4]  = '{1, MC,           16'h8808, 16'h0001, 64, 1, 0, 0, 8'h14, 0, 0, 0, 16'h0000};
    vecs[5]  = '{1, MC,           16'h8808, 16'h0001, 20, 0, 0, 0, 8'h15, 0, 0, 0, 16'h0000};
    vecs[6]  = '{1, MC,           16'h8808, 16'h0001, 34, 0, 0, 0, 8'h16, 0, 1, 0, 16'h0001};
    vecs[7]  = '{1, MC,           16'h8808, 16'h0001, 33, 0, 1, 0, 8'h17, 0, 0, 1, 16'h0000};
    vecs[8]  = '{0, MC,           16'h8808, 16'h0001, 64, 0, 0, 0, 8'h18, 0, 0, 1, 16'h0000};
    vecs[9]  = '{1, MC,           16'h8809, 16'h0001, 64, 0, 0, 0, 8'h19, 1, 0, 1, 16'h0000};
    vecs[10] = '{1, 48'hFFFFFFFFFFFF, 16'h0800, 16'h4500, 60, 0, 0, 0, 8'h1A, 1, 0, 1, 16'h0000};
    vecs[11] = '{1, MC,           16'h8808, 16'h0101, 64, 0, 1, 0, 8'h1B, 1, 1, 1, 16'h0101};

    // Reset state
    #3;
    check("rst s_tready",  256'(s_axis_tready), 256'(0));
    check("rst m_tvalid",  256'({m_axis_tvalid, m_axis_tdata}), 256'(0));
    check("rst mcf",       256'({mcf_valid, stat_rx_mcf, mcf_opcode, mcf_eth_dst}), 256'(0));
    check("rst params",    256'(mcf_params), 256'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 12; v++) begin
      string nm;
      nm = $sformatf("vec%0d", v);
      set_cfg(vecs[v]);
      clear_counts();
      add_frame(vecs[v]);
      drain(nm);
      check({nm, " pulses"}, 256'(pulse_cnt), 256'(vecs[v].exp_pulse ? 1 : 0));
      if (vecs[v].exp_pulse) check_fields(nm, vecs[v].exp_op, vecs[v].dst, vecs[v].tid);
    end

    // Data, dropped LFC, data back-to-back under alternating backpressure
    d0 = '{1, 48'h020000000009, 16'h0800, 16'h4500, 64, 0, 0, 0, 8'h31, 1, 0, 1, 16'h0000};
    lf = '{1, MC,               16'h8808, 16'h0001, 64, 0, 0, 0, 8'h32, 1, 1, 0, 16'h0001};
    d1 = '{1, 48'h02000000000A, 16'h0800, 16'h4500, 60, 0, 0, 0, 8'h33, 1, 0, 1, 16'h0000};
    set_cfg(lf);
    clear_counts();
    add_frame(d0); add_frame(lf); add_frame(d1);
    drain("b2b");
    check("b2b pulses", 256'(pulse_cnt), 256'(1));
    check_fields("b2b", 16'h0001, MC, 8'h32);

    // Two dropped LFCs back-to-back: two separate pulses, record from the second
    lf.tog = 0; lf.tid = 8'h41;
    set_cfg(lf);
    clear_counts();
    add_frame(lf);
    lf.tid = 8'h42;
    add_frame(lf);
    drain("lfc2");
    check("lfc2 pulses", 256'(pulse_cnt), 256'(2));
    check("lfc2 id", 256'(mcf_id), 256'(8'h42));

    // Reset during beat 1 of a 3-beat data frame, then a clean LFC
    d0.len = 96; d0.tog = 0; d0.tid = 8'h70;
    set_cfg(d0);
    clear_counts();
    add_frame(d0);
    step();
    step();
    check("pre_rst m_tvalid", 256'(m_axis_tvalid), 256'(1));
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst axis", 256'({m_axis_tvalid, s_axis_tready, m_axis_tlast, m_axis_tkeep}), 256'(0));
    check("mid_rst data", m_axis_tdata, 256'(0));
    check("mid_rst mcf",  256'({mcf_valid, mcf_opcode, mcf_eth_dst, mcf_id}), 256'(0));
    in_q.delete();
    exp_q.delete();
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    lf.tid = 8'h55;
    set_cfg(lf);
    clear_counts();
    add_frame(lf);
    drain("post_rst");
    check("post_rst pulses", 256'(pulse_cnt), 256'(1));
    check_fields("post_rst", 16'h0001, MC, 8'h55);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mqnic_l2_ingress_mcf.md
Name: mqnic_l2_ingress_mcf

Overview:
Layer 2 ingress block on the receive path, between the MAC RX stream and the internal datapath. It is the receive-side counterpart of the egress MAC control frame (MCF) insertion. It classifies each incoming frame, extracts MAC control frames (LFC/PFC) into a parallel mcf_* record with a one-cycle valid pulse, and passes data frames through a one-stage register. MCFs are either dropped or also forwarded, per cfg.

Parameters:
AXIS_DATA_WIDTH, 256, stream width in bits; legal values 128, 256, 512 (ethertype and opcode always fall in beat 0).
AXIS_KEEP_WIDTH, AXIS_DATA_WIDTH/8, tkeep width.
AXIS_USER_WIDTH, 1, tuser width; bit 0 = bad-frame flag.
ID_WIDTH, 8, tid width.
DEST_WIDTH, 8, tdest width.
MCF_PARAMS_SIZE, 18, MCF parameter bytes following the opcode.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
s_axis_tdata/tkeep/tvalid/tready/tlast/tuser/tid/tdest  in (tready out)  per params  frames from MAC
m_axis_tdata/tkeep/tvalid/tready/tlast/tuser/tid/tdest  out (tready in)  per params  frames to datapath
mcf_valid  out  1  one-cycle pulse: MCF received
mcf_eth_dst  out  48  frame bytes 0-5, byte 0 in [47:40]
mcf_eth_src  out  48  bytes 6-11, byte 6 in [47:40]
mcf_eth_type  out  16  bytes 12-13, big-endian
mcf_opcode  out  16  bytes 14-15, big-endian
mcf_params  out  MCF_PARAMS_SIZE*8  bytes 16.., byte 16 in [7:0]
mcf_id  out  ID_WIDTH  tid of the MCF
mcf_dest  out  DEST_WIDTH  tdest of the MCF
mcf_user  out  AXIS_USER_WIDTH  tuser of the MCF last beat
cfg_mcf_rx_enable  in  1  enable MCF detection
cfg_mcf_rx_eth_type  in  16  ethertype to match (normally 0x8808)
cfg_mcf_rx_eth_dst_ucast  in  48  station unicast address
cfg_mcf_rx_check_eth_dst_ucast  in  1  also accept MCF sent to the ucast address
cfg_mcf_rx_forward  in  1  1 = MCF also forwarded on m_axis
stat_rx_mcf  out  1  pulse, coincident with mcf_valid

Behaviour:
- Reset (async): all outputs 0, state IDLE, mcf_* fields 0, capture buffer cleared.
- Beat 0 classification, combinational in IDLE. is_mcf = enable & type==cfg_eth_type & (dst==01:80:C2:00:00:01 | (check_ucast & dst==cfg_ucast)). Byte n of the frame is tdata[8n+7:8n].
- States:
  - IDLE: on accepted beat 0, go to FWD (not MCF), MCF_FWD (MCF and forward=1) or MCF_DROP (MCF and forward=0). A beat 0 with tlast returns to IDLE.
  - FWD, MCF_FWD, MCF_DROP: on accepted tlast, return to IDLE.
- cfg inputs are sampled at beat 0 only.
- Data path: one output register, latency 1 cycle.
  - FWD/MCF_FWD/IDLE: s_axis_tready = m_axis_tready | ~m_axis_tvalid.
  - MCF_DROP: tready = 1 and m_axis is untouched. Beat 0 of a dropped frame is also accepted unconditionally.
- Capture: byte pointer ptr (16 bit, saturating) advances by AXIS_KEEP_WIDTH per non-last beat. Bytes with index < 16+MCF_PARAMS_SIZE are written into the header buffer.
  - The last beat's byte count is the popcount of tkeep, which is contiguous from bit 0.
  - Total length = ptr + count.
- MCF completion: the cycle after the accepted tlast of an MCF frame, mcf_valid=1 and stat_rx_mcf=1 for exactly one cycle. This requires length >= 16+MCF_PARAMS_SIZE and tuser[0]==0 on the last beat.
  - Otherwise there is no pulse; a dropped frame stays dropped and a forwarded one is still forwarded.
- mcf_* fields update only with mcf_valid and hold until the next MCF. There is no backpressure on the mcf interface.
- Back-to-back MCFs with 1-beat frames produce pulses on consecutive cycles.
- A reset mid-frame discards the partial frame state. The next accepted beat is treated as beat 0.

Decomposition:
- Shared include header holds the constants: MCF_ETHERTYPE 16'h8808, MCF_DST_MCAST 48'h0180C2000001, OPCODE_LFC 16'h0001, OPCODE_PFC 16'h0101, MCF_HDR_BYTES 16.
- One natural sub-module, mqnic_l2_ingress_reg: a single-stage AXIS register with tid/tdest/tuser and an async reset. The classifier, capture and FSM stay in the top.

Test Plan:
- 64-byte IPv4 frame, ethertype 0x0800, width 256 -> forwarded unchanged after 1 cycle latency; mcf_valid never asserted.
- LFC to 01:80:C2:00:00:01, type 0x8808, opcode 0x0001, quanta 0xFFFF, forward=0 -> not on m_axis; tready=1 throughout. One pulse with opcode 0x0001, mcf_params[15:0]=16'hFFFF in frame byte order (0xFF,0xFF), stat_rx_mcf=1.
- PFC to unicast 02:00:00:00:00:01 with check_ucast=1, forward=1 -> frame forwarded and mcf_valid pulses with opcode 0x0101. The same frame with check_ucast=0 -> forwarded, no pulse.
- MCF with tuser[0]=1 on tlast, and a 20-byte MCF -> no mcf_valid; the frame is dropped when forward=0.
- Data, MCF, data back-to-back with m_axis_tready toggling 50% -> data frames intact and in order; exactly one mcf pulse.
- Assert rst in the middle of beat 1 of a 3-beat frame -> all outputs 0 immediately. The following 64-byte MCF is decoded correctly.
